// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback sources.
//   Source A is the in-order pipeline writeback. Source B is the completion of
//   a long-latency unit (multicycle load / divide).
//   A wins ordinary contention. After STARVE_MAX consecutive cycles with B
//   blocked, B is force-granted for one cycle.
//   A pending-destination scoreboard tracks outstanding B operations so that
//   decode can detect RAW/WAW hazards through chk_busy1/chk_busy2.
//   rf_we/rf_wa/rf_wd are registered and drive the regfile we3/wa3/wd3.
//
// Parameters:
//   XLEN        - data width
//   RFIDX_WIDTH - register index width (x0 is hardwired zero)
//   STARVE_MAX  - consecutive blocked B cycles before B is forced (1..15)
//
// Ports:
//   clk, reset             - rising-edge clock, synchronous active-high reset
//   a_valid/a_ready        - A handshake, a_rd/a_wd destination and data
//   b_issue/b_issue_rd     - long-latency op issued; marks its rd pending
//   b_valid/b_ready        - B handshake, b_rd/b_wd destination and data
//   chk_ra1/chk_ra2        - decode source indices to check
//   chk_busy1/chk_busy2    - index pending or being written (combinational)
//   rf_we/rf_wa/rf_wd      - registered regfile write port
//
// Optional feature (macro RF_WB_STATS_EN):
//   Adds stat_conflicts (cycles where A and B both request a real write) and
//   stat_forced (NORMAL -> FORCE_B transitions), both 16-bit saturating.
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int STARVE_MAX  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [RFIDX_WIDTH-1:0] a_rd,
    input  logic [XLEN-1:0]        a_wd,
    input  logic                   b_issue,
    input  logic [RFIDX_WIDTH-1:0] b_issue_rd,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [RFIDX_WIDTH-1:0] b_rd,
    input  logic [XLEN-1:0]        b_wd,
    input  logic [RFIDX_WIDTH-1:0] chk_ra1,
    input  logic [RFIDX_WIDTH-1:0] chk_ra2,
    output logic                   chk_busy1,
    output logic                   chk_busy2,
    output logic                   rf_we,
    output logic [RFIDX_WIDTH-1:0] rf_wa,
    output logic [XLEN-1:0]        rf_wd
`ifdef RF_WB_STATS_EN
    ,
    output logic [15:0]            stat_conflicts,
    output logic [15:0]            stat_forced
`endif
);

    localparam int         NREG       = 1 << RFIDX_WIDTH;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_FORCE_B = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             starve_reg, starve_next;
    logic                   a_acc, b_acc;
    logic                   a_real, b_grant, b_real;
    logic                   wr_en_next;
    logic [RFIDX_WIDTH-1:0] wr_addr_next;
    logic [XLEN-1:0]        wr_data_next;
    logic [NREG-1:0]        pend_reg, pend_next;

    // -----------------------------------------------------------------------
    // Arbitration FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_NORMAL;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
        end
    end

    // -----------------------------------------------------------------------
    // Arbitration FSM: handshakes, starvation counter and next state
    // -----------------------------------------------------------------------
    always_comb begin
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        state_next  = state_reg;
        starve_next = starve_reg;

        if (!reset) begin
            case (state_reg)
                ST_NORMAL: begin
                    a_ready = 1'b1;
                    // An x0 write from A never occupies the port, so B may
                    // go alongside it.
                    b_ready = !(a_valid && (a_rd != '0));
                end
                ST_FORCE_B: begin
                    a_ready = 1'b0;
                    b_ready = 1'b1;
                end
                default: begin
                    a_ready = 1'b0;
                    b_ready = 1'b0;
                end
            endcase
        end

        a_acc = a_valid && a_ready;
        b_acc = b_valid && b_ready;

        if (b_acc || !b_valid) begin
            starve_next = '0;
        end else if (starve_reg != STARVE_LIM) begin
            starve_next = starve_reg + 4'd1;
        end

        // The forced cycle starts on the edge where the blocked streak
        // reaches STARVE_MAX. FORCE_B always ends after one cycle because
        // B is either accepted or has withdrawn.
        case (state_reg)
            ST_NORMAL: begin
                if (starve_next == STARVE_LIM) begin
                    state_next = ST_FORCE_B;
                end
            end
            ST_FORCE_B: begin
                if (b_acc || !b_valid) begin
                    state_next = ST_NORMAL;
                end
            end
            default: state_next = ST_NORMAL;
        endcase
    end

    // -----------------------------------------------------------------------
    // Write-port selection: at most one real write per cycle
    // -----------------------------------------------------------------------
    assign a_real       = a_acc && (a_rd != '0);
    assign b_grant      = b_acc && !a_real;
    assign b_real       = b_grant && (b_rd != '0);
    assign wr_en_next   = a_real || b_real;
    assign wr_addr_next = a_real ? a_rd : b_rd;
    assign wr_data_next = a_real ? a_wd : b_wd;

    // Address/data only move on a real write so the port holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= wr_en_next;
            if (wr_en_next) begin
                rf_wa <= wr_addr_next;
                rf_wd <= wr_data_next;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pending-destination scoreboard; set has priority over clear
    // -----------------------------------------------------------------------
    assign pend_next[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_pend
            logic set_bit;
            logic clr_bit;
            assign set_bit       = b_issue && (b_issue_rd == RFIDX_WIDTH'(gi));
            assign clr_bit       = b_acc && (b_rd == RFIDX_WIDTH'(gi));
            assign pend_next[gi] = set_bit || (pend_reg[gi] && !clr_bit);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // A completed B write is still busy during its rf_we cycle because the
    // regfile commits it only at the falling edge of that cycle.
    assign chk_busy1 = (chk_ra1 != '0) &&
                       (pend_reg[chk_ra1] || (rf_we && (rf_wa == chk_ra1)));
    assign chk_busy2 = (chk_ra2 != '0) &&
                       (pend_reg[chk_ra2] || (rf_we && (rf_wa == chk_ra2)));

`ifdef RF_WB_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating event counters
    // -----------------------------------------------------------------------
    logic        conflict;
    logic        force_entry;
    logic [15:0] conflicts_reg;
    logic [15:0] forced_reg;

    assign conflict    = a_valid && (a_rd != '0) && b_valid && (b_rd != '0);
    assign force_entry = (state_reg == ST_NORMAL) && (state_next == ST_FORCE_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            conflicts_reg <= '0;
            forced_reg    <= '0;
        end else begin
            if (conflict && (conflicts_reg != 16'hFFFF)) begin
                conflicts_reg <= conflicts_reg + 16'd1;
            end
            if (force_entry && (forced_reg != 16'hFFFF)) begin
                forced_reg <= forced_reg + 16'd1;
            end
        end
    end

    assign stat_conflicts = conflicts_reg;
    assign stat_forced    = forced_reg;
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback sources.
- Source A is the in-order pipeline writeback. Source B is the long-latency unit (multicycle load/divide) completion.
- Keeps a pending-destination scoreboard for outstanding B operations, so decode can detect RAW/WAW hazards.
- Sits between the writeback stage and the regfile write port; rf_* outputs drive we3/wa3/wd3 directly.

Parameters:
- XLEN, 32, data width.
- RFIDX_WIDTH, 5, register index width (2^RFIDX_WIDTH registers, x0 hardwired zero).
- STARVE_MAX, 4, consecutive B-blocked cycles before B is force-granted (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  pipeline writeback request.
- a_ready  out  1  A accepted this cycle when a_valid && a_ready.
- a_rd  in  RFIDX_WIDTH  A destination.
- a_wd  in  XLEN  A data.
- b_issue  in  1  long-latency op issued this cycle.
- b_issue_rd  in  RFIDX_WIDTH  destination of issued op.
- b_valid  in  1  long-latency completion request.
- b_ready  out  1  B accepted when b_valid && b_ready.
- b_rd  in  RFIDX_WIDTH  B destination.
- b_wd  in  XLEN  B data.
- chk_ra1, chk_ra2  in  RFIDX_WIDTH  decode source indices to check.
- chk_busy1, chk_busy2  out  1  index has an outstanding or in-flight write (combinational).
- rf_we  out  1  regfile write enable (registered).
- rf_wa  out  RFIDX_WIDTH  regfile write address (registered).
- rf_wd  out  XLEN  regfile write data (registered).

Behaviour:
- Reset (synchronous, active-high): rf_we=0, rf_wa=0, rf_wd=0, pend=0, starve_cnt=0, state=NORMAL. a_ready=0 and b_ready=0 while reset is high.
- Latency: a request accepted at rising edge N drives rf_we/rf_wa/rf_wd during cycle N+1. The regfile commits it at the falling edge inside N+1.
- A request with rd==0 is accepted, dropped, and does not occupy the write port. rf_we stays 0 for it.
- State NORMAL:
  - a_ready=1.
  - b_ready = !(a_valid && a_rd!=0).
  - If both request a real write, A wins.
- starve_cnt:
  - Increments each cycle b_valid && !b_ready, saturating at STARVE_MAX.
  - Clears on B acceptance or when b_valid=0.
  - When starve_cnt==STARVE_MAX at a rising edge, next state=FORCE_B.
- State FORCE_B:
  - a_ready=0, b_ready=1.
  - On B acceptance: state=NORMAL, starve_cnt=0.
  - If b_valid drops before acceptance, return to NORMAL.
- Write port register:
  - Each edge, rf_we = (granted source has rd!=0). rf_wa/rf_wd are loaded from the granted source.
  - With no grant, rf_we=0 and rf_wa/rf_wd hold.
  - Never more than one write per cycle.
- Scoreboard pend[2^RFIDX_WIDTH-1:0], pend[0] always 0:
  - Set: b_issue && b_issue_rd!=0 sets pend[b_issue_rd].
  - Clear: B acceptance clears pend[b_rd].
  - Same index set and cleared in the same cycle: set wins.
  - Issue to an already-pending index leaves it set. Issuers must stall on chk_busy to avoid this.
  - B completion to a non-pending index is written normally, pend unchanged.
- chk_busyN = (chk_raN!=0) && (pend[chk_raN] || (rf_we && rf_wa==chk_raN)).
- Reset mid-operation: pending and in-flight writes are discarded; rf_we=0 in the cycle after reset is sampled.

Optional Feature:
- Macro RF_WB_STATS_EN.
- Defined:
  - Adds output stat_conflicts (16 bits). Increments, saturating at 16'hFFFF, each cycle both A and B request a real write.
  - Adds output stat_forced (16 bits). Increments, saturating, on each NORMAL→FORCE_B transition.
  - Both counters are 0 on reset.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Lone A: a_valid=1, a_rd=5, a_wd=32'h1234 at edge N -> cycle N+1 rf_we=1, rf_wa=5, rf_wd=32'h1234; cycle N+2 rf_we=0.
- Contention: a_valid (rd=3) and b_valid (rd=7) together -> a_ready=1, b_ready=0; A written first; B written the cycle after A drops.
- Starvation: a_valid held with rd=2, b_valid held, STARVE_MAX=4 -> after 4 blocked cycles a_ready=0, b_ready=1 for one cycle; B (rd=9) written; then a_ready=1.
- x0 handling: a_valid with a_rd=0 plus b_valid with b_rd=4 in the same cycle -> both accepted; only x4 written; rf_we never asserts with rf_wa=0.
- Scoreboard:
  - b_issue rd=10 -> chk_ra1=10 gives chk_busy1=1.
  - B completes rd=10 -> busy stays 1 through the rf_we cycle, 0 the cycle after.
  - Simultaneous issue rd=11 and completion rd=11 -> pend[11] remains 1.
- Reset mid-flight: pend[6]=1 and rf_we=1, assert reset one cycle -> rf_we=0, chk_busy for 6 =0, a_ready=b_ready=0 during reset.
